// File: rtl/instr_loader_if.sv
// Load-stream handshake and instruction-memory write bus for instr_loader.
// master: stream source / memory side; slave: the loader itself.
interface instr_loader_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;

    modport master (
        output s_data, s_valid,
        input  s_ready, imem_we, imem_addr, imem_wd
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, imem_we, imem_addr, imem_wd
    );
endinterface

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: 16-bit word-count header, little-endian payload words,
// optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_loader #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_loader_if.slave        bus,
    input  logic                 load_req,
    output logic                 core_rst,
    output logic                 done,
    output logic                 error,
    output logic [15:0]          words_loaded
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {StHdr0, StHdr1, StLoad, StCsum, StDone, StErr} state_e;
`else
    typedef enum logic [2:0] {StHdr0, StHdr1, StLoad, StDone, StErr} state_e;
`endif

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] n_q, n_d;
    logic [15:0] words_q, words_d;
    logic [23:0] buf_q, buf_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        words_d = words_q;
        buf_d   = buf_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wd_d    = wd_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            StHdr0: begin
                if (bus.s_valid) begin
                    n_d[7:0] = bus.s_data;
                    state_d  = StHdr1;
                end
            end
            StHdr1: begin
                if (bus.s_valid) begin
                    n_d[15:8] = bus.s_data;
                    if (n_d == 16'd0) begin
                        state_d = StDone;
                    end else if (32'(n_d) > DEPTH) begin
                        state_d = StErr;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                // Final word's write pulse is in flight; leave LOAD only once it has retired.
                if (words_q == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                    if (bus.s_valid) begin
                        state_d = (bus.s_data == csum_q) ? StDone : StErr;
                    end else begin
                        state_d = StCsum;
                    end
`else
                    state_d = StDone;
`endif
                end else if (bus.s_valid) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q + bus.s_data;
`endif
                    cnt_d = cnt_q + 2'd1;
                    unique case (cnt_q)
                        2'd0: buf_d[7:0]   = bus.s_data;
                        2'd1: buf_d[15:8]  = bus.s_data;
                        2'd2: buf_d[23:16] = bus.s_data;
                        2'd3: begin
                            we_d    = 1'b1;
                            wd_d    = {bus.s_data, buf_q};
                            addr_d  = {14'd0, words_q, 2'b00};
                            words_d = words_q + 16'd1;
                        end
                    endcase
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StCsum: begin
                if (bus.s_valid) begin
                    state_d = (bus.s_data == csum_q) ? StDone : StErr;
                end
            end
`endif
            StDone, StErr: begin
                if (load_req) begin
                    state_d = StHdr0;
                    cnt_d   = 2'd0;
                    n_d     = 16'd0;
                    words_d = 16'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = 8'd0;
`endif
                end
            end
            default: state_d = StHdr0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StHdr0;
            cnt_q   <= 2'd0;
            n_q     <= 16'd0;
            words_q <= 16'd0;
            buf_q   <= 24'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wd_q    <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            words_q <= words_d;
            buf_q   <= buf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        bus.s_ready   = (state_q != StDone) && (state_q != StErr);
        bus.imem_we   = we_q;
        bus.imem_addr = addr_q;
        bus.imem_wd   = wd_q;
        core_rst      = (state_q != StDone);
        done          = (state_q == StDone);
        error         = (state_q == StErr);
        words_loaded  = words_q;
    end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a stream-level model queues expected writes, a monitor
// pops and compares on every imem_we pulse. Honours LOADER_CHECKSUM_EN like the design.
module tb_instr_loader;
    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic        core_rst;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    instr_loader_if bus ();

    instr_loader #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .load_req     (load_req),
        .core_rst     (core_rst),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  stream[$];
    int          checks = 0;
    int          failures = 0;
    bit          exp_done;
    bit          exp_err;
    int          exp_words;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    wr_t mon_e;
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            check("we_outside_done_err", {31'd0, done | error}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr 0x%0h wd 0x%0h expected none",
                         bus.imem_addr, bus.imem_wd);
            end else begin
                mon_e = exp_q.pop_front();
                check("imem_addr", bus.imem_addr, mon_e.addr);
                check("imem_wd", bus.imem_wd, mon_e.wd);
            end
        end
    end

    // Reference model: interpret the whole stream per the loader's rules.
    function automatic void model_stream();
        int         n;
        logic [7:0] sum;
        wr_t        w;
        n = int'({stream[1], stream[0]});
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_words = 0;
        sum       = 8'd0;
        if (n == 0) begin
            exp_done = 1'b1;
        end else if (n > int'(DEPTH)) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                w.addr = 32'(4 * i);
                w.wd   = {stream[2 + 4*i + 3], stream[2 + 4*i + 2],
                          stream[2 + 4*i + 1], stream[2 + 4*i]};
                exp_q.push_back(w);
                for (int j = 0; j < 4; j++) sum = sum + stream[2 + 4*i + j];
            end
            exp_words = n;
`ifdef LOADER_CHECKSUM_EN
            exp_done = (stream[2 + 4*n] == sum);
            exp_err  = !exp_done;
`else
            exp_done = 1'b1;
`endif
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waitc = 0;
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        load_req    = 1'($urandom_range(1));  // noise: must be ignored while loading
        while (bus.s_ready !== 1'b1 && waitc < 50) begin
            tick();
            waitc++;
        end
        if (bus.s_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got s_ready=%b expected 1 within 50 cycles", bus.s_ready);
            bus.s_valid = 1'b0;
            load_req    = 1'b0;
            return;
        end
        tick();
        bus.s_valid = 1'b0;
        load_req    = 1'b0;
    endtask

    task automatic send_stream(input int gap_pct);
        foreach (stream[i]) begin
            send_byte(stream[i]);
            if ($urandom_range(99) < gap_pct) repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    task automatic end_checks();
        repeat (3) tick();
        check("done", {31'd0, done}, {31'd0, exp_done});
        check("error", {31'd0, error}, {31'd0, exp_err});
        check("core_rst", {31'd0, core_rst}, {31'd0, !exp_done});
        check("words_loaded", {16'd0, words_loaded}, 32'(exp_words));
        check("s_ready_end", {31'd0, bus.s_ready}, 32'd0);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic restart();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check("restart_s_ready", {31'd0, bus.s_ready}, 32'd1);
        check("restart_core_rst", {31'd0, core_rst}, 32'd1);
        check("restart_done", {31'd0, done}, 32'd0);
        check("restart_words", {16'd0, words_loaded}, 32'd0);
    endtask

    task automatic run(input int gap_pct);
        model_stream();
        send_stream(gap_pct);
        end_checks();
        restart();
    endtask

    initial begin
        int         n;
        logic [7:0] sum;
        logic [7:0] b;

        rst         = 1'b1;
        load_req    = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'd0;
        repeat (2) tick();
        check("rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
        check("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
        check("rst_imem_addr", bus.imem_addr, 32'd0);
        check("rst_imem_wd", bus.imem_wd, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("rst_words", {16'd0, words_loaded}, 32'd0);
        rst = 1'b0;
        tick();

        // Two words back-to-back, then empty load, then oversize header.
        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(8'h13 + 8'h50 + 8'h93 + 8'hA0);
`endif
        run(0);
        stream = '{8'h00, 8'h00};
        run(0);
        stream = '{8'h01, 8'h04};
        run(0);

        // One word split by a five-cycle idle gap.
        stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(8'h63);
`endif
        model_stream();
        for (int i = 0; i < 4; i++) send_byte(stream[i]);
        repeat (5) tick();
        for (int i = 4; i < stream.size(); i++) send_byte(stream[i]);
        end_checks();
        restart();

`ifdef LOADER_CHECKSUM_EN
        stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h64};
        run(0);
`endif

        // Reset after the third payload byte abandons the partial word.
        stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h50};
        send_stream(0);
        rst = 1'b1;
        #1;
        check("midrst_imem_we", {31'd0, bus.imem_we}, 32'd0);
        check("midrst_words", {16'd0, words_loaded}, 32'd0);
        check("midrst_s_ready", {31'd0, bus.s_ready}, 32'd1);
        check("midrst_core_rst", {31'd0, core_rst}, 32'd1);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(8'h13 + 8'h50 + 8'h93 + 8'hA0);
`endif
        run(30);

        // Randomized loads, including empty, oversize and bad-checksum streams.
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(9))
                0:       n = 0;
                1:       n = int'(DEPTH) + 1 + int'($urandom_range(2000));
                default: n = int'($urandom_range(1, 6));
            endcase
            stream.delete();
            stream.push_back(8'(n));
            stream.push_back(8'(n >> 8));
            sum = 8'd0;
            if (n <= int'(DEPTH)) begin
                for (int i = 0; i < 4 * n; i++) begin
                    b = 8'($urandom);
                    stream.push_back(b);
                    sum = sum + b;
                end
`ifdef LOADER_CHECKSUM_EN
                if (n != 0) stream.push_back(sum + 8'($urandom_range(1) == 1 ? 1 : 0));
`endif
            end
            run(25);
        end

        // Full-capacity load.
        stream.delete();
        stream.push_back(8'(DEPTH));
        stream.push_back(8'(DEPTH >> 8));
        sum = 8'd0;
        for (int i = 0; i < 4 * int'(DEPTH); i++) begin
            b = 8'($urandom);
            stream.push_back(b);
            sum = sum + b;
        end
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(sum);
`endif
        run(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning instruction memory capacity in 32-bit words.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port s_data  input  8  incoming load-stream byte.
REQ-005 SHALL have port s_valid  input  1  s_data is valid this cycle.
REQ-006 SHALL have port s_ready  output  1  loader accepts a byte this cycle; a byte transfers when s_valid and s_ready are both 1 at a rising edge.
REQ-007 SHALL have port load_req  input  1  request to restart loading from state DONE or ERR.
REQ-008 SHALL have port imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 SHALL have port imem_addr  output  32  byte address of the word being written.
REQ-010 SHALL have port imem_wd  output  32  instruction word being written.
REQ-011 SHALL have port core_rst  output  1  reset for the processor core; held high while not in DONE.
REQ-012 SHALL have port done  output  1  load completed successfully.
REQ-013 SHALL have port error  output  1  load aborted.
REQ-014 SHALL have port words_loaded  output  16  count of words written in the current load.

Function
REQ-015 SHALL implement states HDR0, HDR1, LOAD, CSUM, DONE, ERR.
REQ-016 SHALL drive s_ready = 1 in HDR0, HDR1, LOAD and CSUM, and 0 in DONE and ERR; s_ready is decoded from state only, with no dependence on s_valid.
REQ-017 HDR0: an accepted byte SHALL become word count N[7:0]; next state HDR1.
REQ-018 HDR1: an accepted byte SHALL become N[15:8]; next state is DONE if N = 0, ERR if N > DEPTH, else LOAD.
REQ-019 LOAD: bytes SHALL assemble little-endian, with the first byte going to [7:0] and the fourth to [31:24].
REQ-020 LOAD: imem_we SHALL pulse high for exactly one cycle, in the cycle after the fourth byte is accepted, with imem_wd = the assembled word and imem_addr = 4 * words_loaded (value before increment).
REQ-021 words_loaded SHALL increment in the same cycle that imem_we is high.
REQ-022 After the N-th word is written, the next state SHALL be CSUM if LOADER_CHECKSUM_EN is defined, else DONE.
REQ-023 The byte assembly counter SHALL wrap from 3 to 0 on each completed word.
REQ-024 A cycle with s_valid = 0 SHALL leave all state unchanged; gaps between bytes are allowed in any state.
REQ-025 core_rst SHALL be 1 in every state except DONE.
REQ-026 done SHALL be 1 only in DONE, and error SHALL be 1 only in ERR.
REQ-027 In DONE or ERR, load_req = 1 SHALL return the state to HDR0, clear words_loaded, clear the checksum and assert core_rst on the next cycle.
REQ-028 load_req SHALL be ignored in all other states.
REQ-029 s_valid SHALL be ignored in DONE and ERR.
REQ-030 imem_we SHALL be 0 outside the write pulse, and SHALL never be asserted in HDR0, HDR1, CSUM, DONE or ERR.

Reset
REQ-031 rst = 1 SHALL asynchronously force state HDR0, the byte counter to 0, N = 0, words_loaded = 0, checksum = 0, imem_we = 0, imem_addr = 0, imem_wd = 0, done = 0, error = 0 and core_rst = 1.
REQ-032 rst asserted mid-load SHALL abandon the partial word with no write and no further imem_we pulse.

Configuration
REQ-033 Macro LOADER_CHECKSUM_EN: when defined, the block SHALL keep an 8-bit sum modulo 256 of all payload bytes (header bytes excluded); the CSUM state SHALL accept one byte and go to DONE if that byte equals the sum, else to ERR.
REQ-034 Without LOADER_CHECKSUM_EN, there SHALL be no CSUM state, no checksum logic, and the load SHALL go directly to DONE after the last word.

Verification
REQ-035 Stream 02 00 13 00 50 00 93 00 A0 00, streamed back-to-back -> imem_we pulses with addr 0x0 / wd 0x00500013, then addr 0x4 / wd 0x00A00093; done = 1; core_rst = 0; words_loaded = 2.
REQ-036 Stream 00 00 -> DONE reached directly from HDR1 with no imem_we pulse and words_loaded = 0.
REQ-037 With DEPTH = 1024, stream 01 04 (N = 1025) -> error = 1, s_ready = 0, core_rst = 1; then load_req pulse -> returns to HDR0 and s_ready = 1.
REQ-038 Stream 01 00 13 00, then s_valid = 0 for 5 cycles, then 50 00 -> a single write of 0x00500013 to addr 0x0; no write occurs during the gap.
REQ-039 With LOADER_CHECKSUM_EN, stream 01 00 13 00 50 00 63 -> DONE; the same payload with checksum byte 64 -> ERR.
REQ-040 rst asserted after the third payload byte -> imem_we = 0, state HDR0, words_loaded = 0; a subsequent clean stream loads correctly.
